// File: rtl/barrel_cmd_fifo_if.sv
// Command handshake bundle between producer, FIFO and the barrel shifter.
// Upstream push side (in_*) and downstream head side (out_*).
interface barrel_cmd_fifo_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_cmd;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_cmd;

    modport master (
        output in_valid, in_cmd, out_ready,
        input  in_ready, out_valid, out_cmd
    );

    modport slave (
        input  in_valid, in_cmd, out_ready,
        output in_ready, out_valid, out_cmd
    );
endinterface

// File: rtl/barrel_cmd_fifo.sv
// First-word fall-through command FIFO feeding a 4-bit barrel shifter.
// No-op commands (rot=dir=amt=0) are swallowed and flagged in nop_drop.
module barrel_cmd_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    barrel_cmd_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     nop_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          is_nop;
    logic          accept;
    logic          push;
    logic          pop;

    assign bus.in_ready  = rst_n && !flush && (level < FULL);
    assign bus.out_valid = (level != '0) && !flush;
    assign bus.out_cmd   = (level != '0) ? mem[rd_ptr] : 8'h00;

    assign is_nop = (bus.in_cmd[7:4] == 4'h0);
    assign accept = bus.in_valid && bus.in_ready;
    assign push   = accept && !is_nop;
    assign pop    = bus.out_valid && bus.out_ready;

    // Storage is data only; validity is tracked by level and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_cmd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            nop_drop <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            nop_drop <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (accept && is_nop) begin
                nop_drop <= 1'b1;
            end
            unique case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_barrel_cmd_fifo.sv
// Directed table-driven bench for barrel_cmd_fifo (DEPTH=4).
// Each vector is applied for one edge; state is checked with inputs idle.
module tb_barrel_cmd_fifo;
    logic       clk;
    logic       rst_n;
    logic       flush;
    logic [2:0] level;
    logic       nop_drop;
    int         checks;
    int         errors;

    barrel_cmd_fifo_if bus ();

    barrel_cmd_fifo #(.DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .bus      (bus),
        .level    (level),
        .nop_drop (nop_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] cmd;
        logic       ordy;
        logic [2:0] lvl;
        logic       ov;
        logic [7:0] oc;
        logic       ir;
        logic       nd;
    } vec_t;

    vec_t vt [17];
    logic [7:0] model [$];

    task automatic chk(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_cmd    = 8'h00;
        bus.out_ready = 1'b0;
    endtask

    task automatic step(input logic fl, input logic iv,
                        input logic [7:0] cmd, input logic ordy);
        @(negedge clk);
        flush         = fl;
        bus.in_valid  = iv;
        bus.in_cmd    = cmd;
        bus.out_ready = ordy;
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] lvl,
                             input logic ov, input logic [7:0] oc,
                             input logic ir, input logic nd);
        chk({tag, ".level"}, {5'd0, level}, {5'd0, lvl});
        chk({tag, ".out_valid"}, {7'd0, bus.out_valid}, {7'd0, ov});
        chk({tag, ".out_cmd"}, bus.out_cmd, oc);
        chk({tag, ".in_ready"}, {7'd0, bus.in_ready}, {7'd0, ir});
        chk({tag, ".nop_drop"}, {7'd0, nop_drop}, {7'd0, nd});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // fl iv cmd ordy | lvl ov oc ir nd
        vt[0]  = '{1'b0, 1'b1, 8'h35, 1'b0, 3'd1, 1'b1, 8'h35, 1'b1, 1'b0};
        vt[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 8'h11, 1'b0, 3'd1, 1'b1, 8'h11, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 8'h22, 1'b0, 3'd2, 1'b1, 8'h11, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 8'h33, 1'b0, 3'd3, 1'b1, 8'h11, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 8'h44, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 8'h11, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 8'h55, 1'b1, 3'd3, 1'b1, 8'h22, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 1'b1, 8'h33, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 1'b1, 8'h44, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b1, 8'h21, 1'b0, 3'd1, 1'b1, 8'h21, 1'b1, 1'b0};
        vt[12] = '{1'b0, 1'b1, 8'h92, 1'b1, 3'd1, 1'b1, 8'h92, 1'b1, 1'b0};
        vt[13] = '{1'b0, 1'b1, 8'h07, 1'b0, 3'd1, 1'b1, 8'h92, 1'b1, 1'b1};
        vt[14] = '{1'b0, 1'b1, 8'h40, 1'b0, 3'd2, 1'b1, 8'h92, 1'b1, 1'b1};
        vt[15] = '{1'b1, 1'b1, 8'h55, 1'b1, 3'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[16] = '{1'b0, 1'b1, 8'h80, 1'b0, 3'd1, 1'b1, 8'h80, 1'b1, 1'b0};

        idle();
        rst_n = 1'b0;
        #12;
        chk_state("reset", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({"post_reset.in_ready"}, {7'd0, bus.in_ready}, 8'h01);

        for (int i = 0; i < 17; i++) begin
            step(vt[i].fl, vt[i].iv, vt[i].cmd, vt[i].ordy);
            chk_state($sformatf("vec%0d", i), vt[i].lvl, vt[i].ov,
                      vt[i].oc, vt[i].ir, vt[i].nd);
        end

        // Steady push+pop at level 2 across several pointer wraps.
        model.push_back(8'h80);
        step(1'b0, 1'b1, 8'hC1, 1'b0);
        model.push_back(8'hC1);
        chk("wrap_fill.level", {5'd0, level}, 8'd2);
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            d = 8'hD0 + 8'(i);
            chk($sformatf("wrap%0d.head_before", i), bus.out_cmd, model[0]);
            step(1'b0, 1'b1, d, 1'b1);
            void'(model.pop_front());
            model.push_back(d);
            chk($sformatf("wrap%0d.level", i), {5'd0, level}, 8'd2);
            chk($sformatf("wrap%0d.out_cmd", i), bus.out_cmd, model[0]);
        end

        // Asynchronous reset with three entries queued.
        step(1'b0, 1'b1, 8'hE1, 1'b0);
        chk("pre_rst.level", {5'd0, level}, 8'd3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b1, 8'hA1, 1'b0);
        chk_state("after_rst", 3'd1, 1'b1, 8'hA1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrel_cmd_fifo.md
BARREL_CMD_FIFO -- requirements
Module: barrel_cmd_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of command entries; legal values 2, 4, 8, 16; other values are unsupported.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port flush, input, 1, synchronous clear of all queued commands.
REQ-005 SHALL have port in_valid, input, 1, upstream command present.
REQ-006 SHALL have port in_ready, output, 1, command accepted this cycle when high with in_valid.
REQ-007 SHALL have port in_cmd, input, 8, command {rot, dir, amt[1:0], data[3:0]}.
REQ-008 SHALL have port out_valid, output, 1, head command presented to the downstream 4-bit barrel shifter.
REQ-009 SHALL have port out_ready, input, 1, downstream shifter consumes the head when high with out_valid.
REQ-010 SHALL have port out_cmd, output, 8, head command, same field layout as in_cmd.
REQ-011 SHALL have port level, output, log2(DEPTH)+1, current occupancy 0..DEPTH.
REQ-012 SHALL have port nop_drop, output, 1, sticky flag: a no-op command was discarded.

Function
REQ-013 SHALL store accepted commands in order and SHALL present them on out_cmd strictly first-in first-out.
REQ-014 SHALL drive in_ready = (level < DEPTH) AND NOT flush, combinationally; in_ready SHALL NOT depend on out_ready.
REQ-015 SHALL push in_cmd on an edge where in_valid AND in_ready.
REQ-016 SHALL drive out_valid = (level > 0) AND NOT flush; out_cmd SHALL equal the head entry (first-word fall-through) with no combinational path from in_cmd.
REQ-017 SHALL pop the head on an edge where out_valid AND out_ready.
REQ-018 SHALL make a command pushed into an empty FIFO at edge N visible with out_valid=1 in the cycle after edge N (1-cycle latency, no bypass).
REQ-019 SHALL, on simultaneous push and pop, keep level unchanged and keep order intact, including at level = 1.
REQ-020 SHALL, when full, refuse pushes even if a pop occurs in the same cycle.
REQ-021 SHALL discard (accept with in_ready, never store) any command with amt = 0 AND rot = 0 AND dir = 0 (no-op), and SHALL set nop_drop to 1 on that edge.
REQ-022 SHALL keep nop_drop at 1 until reset or flush.
REQ-023 SHALL, when flush = 1 at an edge, set level to 0, clear read/write pointers and nop_drop, and ignore any push or pop that cycle.
REQ-024 SHALL wrap read and write pointers modulo DEPTH with no gap or duplicate entry.
REQ-025 SHALL hold out_cmd stable while out_valid = 1 and out_ready = 0.
REQ-026 SHALL update level by +1 (push only), -1 (pop only), or 0 (both or neither).

Reset
REQ-027 SHALL, while rst_n = 0, asynchronously force level = 0, out_valid = 0, nop_drop = 0, pointers = 0; in_ready = 0 during reset.
REQ-028 SHALL drive out_cmd = 8'h00 while empty and during reset.
REQ-029 SHALL discard all queued commands on reset assertion mid-operation and SHALL accept pushes from the first edge after rst_n deasserts.
REQ-030 SHALL NOT require storage-array contents to be reset; only control state is reset.

Verification
REQ-031 SHALL cover: push 8'h35 into empty FIFO with out_ready = 0 -> next cycle out_valid = 1, out_cmd = 8'h35, level = 1.
REQ-032 SHALL cover: DEPTH=4, push 8'h11, 8'h22, 8'h33, 8'h44 with out_ready = 0 -> level = 4, in_ready = 0; 8'h55 offered and not accepted; pops return 11, 22, 33, 44 in order.
REQ-033 SHALL cover: level = 1 holding 8'h21, push 8'h92 and pop same edge -> level = 1, out_cmd = 8'h92.
REQ-034 SHALL cover: push 8'h07 (no-op) -> level unchanged, nop_drop = 1; later flush -> nop_drop = 0, level = 0.
REQ-035 SHALL cover: level = 3, assert rst_n = 0 mid-cycle -> out_valid = 0, level = 0 immediately without a clock edge; after release push 8'hA1 -> out_cmd = 8'hA1 next cycle.
REQ-036 SHALL cover: 10 consecutive push/pop cycles at level 2 -> pointers wrap, output order equals input order, level stays 2.
